simd_mem_loader: RTL and testbench



---
 rtl/simd_mem_loader.sv | 161 ++++++++++++++++
 tb/tb_simd_mem_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_mem_loader.sv
// simd_mem_loader: boot loader that streams 32-bit words into the simd_top IMEM/CP DMEM/PE DMEM and releases the core
// Ports: iClk/iReset (async, active-high); iStart starts a load from IDLE or DONE;
//        iIn_Valid/oIn_Ready/iIn_Data form the word stream; oBus_* are the registered memory write ports;
//        oCore_Reset holds simd_top in reset while loading; iTask_Finished/iPC come back from the core;
//        oDone flags the end of the program.
// Optional: define SIMD_LOADER_PC_STALL_EN to also finish RUN when iPC stays unchanged for STALL_CYCLES cycles.
module simd_mem_loader #(
   parameter int IMEM_DEPTH    = 256,
   parameter int CP_DMEM_DEPTH = 256,
   parameter int PE_DMEM_DEPTH = 256,
   parameter int PE_NUM        = 4,
   parameter int STALL_CYCLES  = 8
) (
   input  logic                               iClk,
   input  logic                               iReset,
   input  logic                               iStart,
   input  logic                               iIn_Valid,
   output logic                               oIn_Ready,
   input  logic [31:0]                        iIn_Data,
   output logic                               oBus_IMEM_Valid,
   output logic                               oBus_IMEM_Write_Enable,
   output logic [$clog2(IMEM_DEPTH)-1:0]      oBus_IMEM_Address,
   output logic [63:0]                        oBus_IMEM_Write_Data,
   output logic                               oBus_CP_DMEM_Valid,
   output logic                               oBus_CP_DMEM_Write_Enable,
   output logic [$clog2(CP_DMEM_DEPTH)+1:0]   oBus_CP_DMEM_Address,
   output logic [31:0]                        oBus_CP_DMEM_Write_Data,
   output logic                               oBus_PE_DMEM_Valid,
   output logic                               oBus_PE_DMEM_Write_Enable,
   output logic [$clog2(PE_DMEM_DEPTH)+1:0]   oBus_PE_DMEM_Address,
   output logic [32*PE_NUM-1:0]               oBus_PE_DMEM_Write_Data,
   output logic                               oCore_Reset,
   input  logic                               iTask_Finished,
   input  logic [$clog2(IMEM_DEPTH)-1:0]      iPC,
   output logic                               oDone
);
   localparam int IW  = $clog2(IMEM_DEPTH);
   localparam int CW  = $clog2(CP_DMEM_DEPTH);
   localparam int PW  = $clog2(PE_DMEM_DEPTH);
   localparam int AW  = (IW > CW) ? ((IW > PW) ? IW : PW) : ((CW > PW) ? CW : PW);
   localparam int SBW = $clog2(PE_NUM + 1);
   typedef enum logic [2:0] {S_IDLE, S_LD_IMEM, S_LD_CPDM, S_LD_PEDM, S_RUN, S_DONE} state_t;
   state_t                r_state, w_next;
   logic [SBW-1:0]        r_sub;
   logic [AW-1:0]         r_addr;
   logic [32*PE_NUM-1:0]  r_buf, w_pe_data;
   logic                  r_core_rst, r_imem_v, r_cp_v, r_pe_v;
   logic [IW-1:0]         r_imem_addr;
   logic [63:0]           r_imem_data;
   logic [CW+1:0]         r_cp_addr;
   logic [31:0]           r_cp_data;
   logic [PW+1:0]         r_pe_addr;
   logic [32*PE_NUM-1:0]  r_pe_data;
   logic                  w_acc, w_last, w_end, w_stall, w_finish;
   assign oIn_Ready = (r_state == S_LD_IMEM) || (r_state == S_LD_CPDM) || (r_state == S_LD_PEDM);
   assign w_acc     = iIn_Valid && oIn_Ready;
   assign w_last    = (r_state == S_LD_CPDM) ||
                      (r_state == S_LD_IMEM && r_sub == SBW'(1)) ||
                      (r_state == S_LD_PEDM && r_sub == SBW'(PE_NUM - 1));
   assign w_end     = (r_state == S_LD_IMEM && r_addr == AW'(IMEM_DEPTH - 1)) ||
                      (r_state == S_LD_CPDM && r_addr == AW'(CP_DMEM_DEPTH - 1)) ||
                      (r_state == S_LD_PEDM && r_addr == AW'(PE_DMEM_DEPTH - 1));
   assign w_finish  = iTask_Finished || w_stall;
`ifdef SIMD_LOADER_PC_STALL_EN
   localparam int SW = $clog2(STALL_CYCLES + 1);
   logic [SW-1:0] r_stall;
   logic [IW-1:0] r_pc_prev;
   // r_stall counts consecutive unchanged-PC cycles; held at 0 outside RUN so entry starts fresh
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         r_stall   <= '0;
         r_pc_prev <= '0;
      end else begin
         r_pc_prev <= iPC;
         r_stall   <= (r_state != S_RUN || iPC != r_pc_prev) ? '0 : r_stall + 1'b1;
      end
   end
   assign w_stall = (r_state == S_RUN) && (iPC == r_pc_prev) && (r_stall == SW'(STALL_CYCLES - 1));
`else
   assign w_stall = (STALL_CYCLES < 0) && (&iPC);
`endif
   // The final lane of a PE address comes straight from the stream, earlier lanes from the buffer
   always_comb begin
      w_pe_data = r_buf;
      w_pe_data[32*(PE_NUM-1) +: 32] = iIn_Data;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    w_next = iStart ? S_LD_IMEM : S_IDLE;
         S_LD_IMEM: w_next = (w_acc && w_last && w_end) ? S_LD_CPDM : S_LD_IMEM;
         S_LD_CPDM: w_next = (w_acc && w_last && w_end) ? S_LD_PEDM : S_LD_CPDM;
         S_LD_PEDM: w_next = (w_acc && w_last && w_end) ? S_RUN : S_LD_PEDM;
         S_RUN:     w_next = w_finish ? S_DONE : S_RUN;
         S_DONE:    w_next = iStart ? S_LD_IMEM : S_DONE;
         default:   w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         r_state     <= S_IDLE;
         r_core_rst  <= 1'b1;
         r_sub       <= '0;
         r_addr      <= '0;
         r_buf       <= '0;
         r_imem_v    <= 1'b0;
         r_imem_addr <= '0;
         r_imem_data <= '0;
         r_cp_v      <= 1'b0;
         r_cp_addr   <= '0;
         r_cp_data   <= '0;
         r_pe_v      <= 1'b0;
         r_pe_addr   <= '0;
         r_pe_data   <= '0;
      end else begin
         r_state    <= w_next;
         // Release is delayed one cycle past RUN entry so the last PE write lands while the core is in reset
         r_core_rst <= !(w_next == S_DONE || (w_next == S_RUN && r_state == S_RUN));
         r_imem_v   <= 1'b0;
         r_cp_v     <= 1'b0;
         r_pe_v     <= 1'b0;
         if (w_acc && !w_last) begin
            r_buf[32*r_sub +: 32] <= iIn_Data;
            r_sub <= r_sub + 1'b1;
         end
         if (w_acc && w_last) begin
            r_sub    <= '0;
            r_addr   <= w_end ? '0 : r_addr + 1'b1;
            r_imem_v <= (r_state == S_LD_IMEM);
            r_cp_v   <= (r_state == S_LD_CPDM);
            r_pe_v   <= (r_state == S_LD_PEDM);
            if (r_state == S_LD_IMEM) begin
               r_imem_addr <= r_addr[IW-1:0];
               r_imem_data <= {iIn_Data, r_buf[31:0]};
            end
            if (r_state == S_LD_CPDM) begin
               r_cp_addr <= {r_addr[CW-1:0], 2'b00};
               r_cp_data <= iIn_Data;
            end
            if (r_state == S_LD_PEDM) begin
               r_pe_addr <= {r_addr[PW-1:0], 2'b00};
               r_pe_data <= w_pe_data;
            end
         end
      end
   end
   assign oBus_IMEM_Valid           = r_imem_v;
   assign oBus_IMEM_Write_Enable    = r_imem_v;
   assign oBus_IMEM_Address         = r_imem_addr;
   assign oBus_IMEM_Write_Data      = r_imem_data;
   assign oBus_CP_DMEM_Valid        = r_cp_v;
   assign oBus_CP_DMEM_Write_Enable = r_cp_v;
   assign oBus_CP_DMEM_Address      = r_cp_addr;
   assign oBus_CP_DMEM_Write_Data   = r_cp_data;
   assign oBus_PE_DMEM_Valid        = r_pe_v;
   assign oBus_PE_DMEM_Write_Enable = r_pe_v;
   assign oBus_PE_DMEM_Address      = r_pe_addr;
   assign oBus_PE_DMEM_Write_Data   = r_pe_data;
   assign oCore_Reset               = r_core_rst;
   assign oDone                     = (r_state == S_DONE);
endmodule

// File: tb/tb_simd_mem_loader.sv
// tb_simd_mem_loader: randomized self-checking bench for simd_mem_loader against a stream-format reference model
module tb_simd_mem_loader;
   localparam int ID = 4, CD = 2, PD = 2, PN = 4;
   localparam int NW = 2*ID + CD + PN*PD;
   logic         iClk = 0, iReset = 0, iStart = 0, iIn_Valid = 0, iTask_Finished = 0;
   logic [31:0]  iIn_Data = '0;
   logic [1:0]   iPC = '0;
   logic         oIn_Ready, oBus_IMEM_Valid, oBus_IMEM_Write_Enable, oBus_CP_DMEM_Valid, oBus_CP_DMEM_Write_Enable;
   logic         oBus_PE_DMEM_Valid, oBus_PE_DMEM_Write_Enable, oCore_Reset, oDone;
   logic [1:0]   oBus_IMEM_Address;
   logic [63:0]  oBus_IMEM_Write_Data;
   logic [2:0]   oBus_CP_DMEM_Address, oBus_PE_DMEM_Address;
   logic [31:0]  oBus_CP_DMEM_Write_Data;
   logic [127:0] oBus_PE_DMEM_Write_Data;
   int n_cmp = 0, n_err = 0, n_viol = 0, pc_mode = 0, pc_t = 0;
   bit acc_prev = 0;
   logic [1:0]   q_ia[$];
   logic [63:0]  q_id[$];
   logic [2:0]   q_ca[$], q_pa[$];
   logic [31:0]  q_cd[$];
   logic [127:0] q_pd[$];

   simd_mem_loader #(.IMEM_DEPTH(ID), .CP_DMEM_DEPTH(CD), .PE_DMEM_DEPTH(PD), .PE_NUM(PN), .STALL_CYCLES(8)) dut (
      .iClk(iClk), .iReset(iReset), .iStart(iStart), .iIn_Valid(iIn_Valid), .oIn_Ready(oIn_Ready),
      .iIn_Data(iIn_Data), .oBus_IMEM_Valid(oBus_IMEM_Valid), .oBus_IMEM_Write_Enable(oBus_IMEM_Write_Enable),
      .oBus_IMEM_Address(oBus_IMEM_Address), .oBus_IMEM_Write_Data(oBus_IMEM_Write_Data),
      .oBus_CP_DMEM_Valid(oBus_CP_DMEM_Valid), .oBus_CP_DMEM_Write_Enable(oBus_CP_DMEM_Write_Enable),
      .oBus_CP_DMEM_Address(oBus_CP_DMEM_Address), .oBus_CP_DMEM_Write_Data(oBus_CP_DMEM_Write_Data),
      .oBus_PE_DMEM_Valid(oBus_PE_DMEM_Valid), .oBus_PE_DMEM_Write_Enable(oBus_PE_DMEM_Write_Enable),
      .oBus_PE_DMEM_Address(oBus_PE_DMEM_Address), .oBus_PE_DMEM_Write_Data(oBus_PE_DMEM_Write_Data),
      .oCore_Reset(oCore_Reset), .iTask_Finished(iTask_Finished), .iPC(iPC), .oDone(oDone));

   always #5 iClk = ~iClk;

   // PC source: mode 0 changes every cycle, 1 holds, 2 changes every 7 cycles
   always @(posedge iClk) begin
      #1;
      pc_t++;
      if (pc_mode == 0 || (pc_mode == 2 && pc_t % 7 == 0)) iPC = iPC + 2'd1;
   end

   // Bus monitor: log every write, and flag pulses with valid != write-enable or not preceded by an accepted word
   always @(negedge iClk) begin
      if (oBus_IMEM_Valid !== oBus_IMEM_Write_Enable || oBus_CP_DMEM_Valid !== oBus_CP_DMEM_Write_Enable ||
          oBus_PE_DMEM_Valid !== oBus_PE_DMEM_Write_Enable) n_viol++;
      if ((oBus_IMEM_Valid || oBus_CP_DMEM_Valid || oBus_PE_DMEM_Valid) && !acc_prev) n_viol++;
      if (oBus_IMEM_Valid) begin q_ia.push_back(oBus_IMEM_Address); q_id.push_back(oBus_IMEM_Write_Data); end
      if (oBus_CP_DMEM_Valid) begin q_ca.push_back(oBus_CP_DMEM_Address); q_cd.push_back(oBus_CP_DMEM_Write_Data); end
      if (oBus_PE_DMEM_Valid) begin q_pa.push_back(oBus_PE_DMEM_Address); q_pd.push_back(oBus_PE_DMEM_Write_Data); end
      acc_prev = iIn_Valid && oIn_Ready;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_q();
      q_ia.delete(); q_id.delete(); q_ca.delete(); q_cd.delete(); q_pa.delete(); q_pd.delete();
      n_viol = 0;
   endtask

   task automatic pulse_start();
      iStart = 1;
      @(posedge iClk); #1;
      iStart = 0;
   endtask

   task automatic restart();
      iTask_Finished = 1;
      @(posedge iClk); #1;
      iTask_Finished = 0;
      pulse_start();
   endtask

   task automatic test_reset();
      iReset = 1;
      repeat (3) @(posedge iClk);
      #1 iReset = 0;
      @(negedge iClk);
      n_cmp++;
      if ({oBus_IMEM_Valid, oBus_IMEM_Write_Enable, oBus_CP_DMEM_Valid, oBus_CP_DMEM_Write_Enable,
           oBus_PE_DMEM_Valid, oBus_PE_DMEM_Write_Enable} !== 6'b0) begin
         n_err++; $display("FAIL reset_valids: got %b want 0", {oBus_IMEM_Valid, oBus_CP_DMEM_Valid, oBus_PE_DMEM_Valid});
      end
      n_cmp++;
      if ({oBus_IMEM_Address, oBus_IMEM_Write_Data, oBus_CP_DMEM_Address, oBus_CP_DMEM_Write_Data,
           oBus_PE_DMEM_Address, oBus_PE_DMEM_Write_Data} !== '0) begin
         n_err++; $display("FAIL reset_bus_data: nonzero bus address/data, want all 0");
      end
      n_cmp++;
      if ({oIn_Ready, oDone, oCore_Reset} !== 3'b001) begin
         n_err++; $display("FAIL reset_ctrl: ready/done/core_reset got %b want 001", {oIn_Ready, oDone, oCore_Reset});
      end
      @(negedge iClk);
      n_cmp++;
      if (oIn_Ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b want 0", oIn_Ready); end
   endtask

   // Streams one complete image (optionally with valid gaps and an iStart pulse at word start_idx)
   // and checks every bus write against the section/order rules of the stream format.
   task automatic test_load(input string nm, input bit gap, input bit seq, input int start_idx);
      logic [31:0]  w [NW];
      logic [127:0] ep;
      int i = 0, t = 0, k_pe = -5, k_rel = -1, base;
      bit acc, sent = 0;
      for (int k = 0; k < NW; k++) w[k] = seq ? 32'(k + 1) : $urandom;
      clear_q();
      while (i < NW && t < 200) begin
         iIn_Valid = gap ? (t % 2 == 0) : 1'b1;
         iIn_Data  = w[i];
         if (i == start_idx && !sent) begin iStart = 1; sent = 1; end
         acc = iIn_Valid && oIn_Ready;
         @(posedge iClk); #1;
         iStart = 0;
         if (acc) i++;
         t++;
      end
      iIn_Valid = 0;
      n_cmp++;
      if (i != NW) begin n_err++; $display("FAIL %s stream_timeout: accepted %0d want %0d", nm, i, NW); end
      for (int k = 0; k < 10 && k_rel < 0; k++) begin
         @(negedge iClk);
         if (oBus_PE_DMEM_Valid && k_pe < 0) k_pe = k;
         if (oCore_Reset === 1'b0) k_rel = k;
      end
      n_cmp++;
      if (k_rel != k_pe + 1) begin
         n_err++; $display("FAIL %s core_release: release at %0d want %0d (last pe write +1)", nm, k_rel, k_pe + 1);
      end
      n_cmp++;
      if (q_ia.size() != ID || q_ca.size() != CD || q_pa.size() != PD) begin
         n_err++;
         $display("FAIL %s write_counts: got imem %0d cp %0d pe %0d want %0d %0d %0d", nm,
                  q_ia.size(), q_ca.size(), q_pa.size(), ID, CD, PD);
      end else begin
         for (int e = 0; e < ID; e++) begin
            n_cmp++;
            if (q_ia[e] !== 2'(e) || q_id[e] !== {w[2*e+1], w[2*e]}) begin
               n_err++; $display("FAIL %s imem[%0d]: got %h@%0d want %h@%0d", nm, e, q_id[e], q_ia[e], {w[2*e+1], w[2*e]}, e);
            end
         end
         for (int a = 0; a < CD; a++) begin
            n_cmp++;
            if (q_ca[a] !== 3'(4*a) || q_cd[a] !== w[2*ID+a]) begin
               n_err++; $display("FAIL %s cp[%0d]: got %h@%0d want %h@%0d", nm, a, q_cd[a], q_ca[a], w[2*ID+a], 4*a);
            end
         end
         for (int p = 0; p < PD; p++) begin
            base = 2*ID + CD + PN*p;
            for (int l = 0; l < PN; l++) ep[32*l +: 32] = w[base+l];
            n_cmp++;
            if (q_pa[p] !== 3'(4*p) || q_pd[p] !== ep) begin
               n_err++; $display("FAIL %s pe[%0d]: got %h@%0d want %h@%0d", nm, p, q_pd[p], q_pa[p], ep, 4*p);
            end
         end
      end
      n_cmp++;
      if (n_viol != 0) begin n_err++; $display("FAIL %s pulse_rules: %0d bad write pulses want 0", nm, n_viol); end
   endtask

   task automatic test_ignored_run();
      clear_q();
      iIn_Valid = 1;
      iIn_Data  = $urandom;
      for (int k = 0; k < 6; k++) begin
         @(negedge iClk);
         n_cmp++;
         if ({oIn_Ready, oCore_Reset, oDone} !== 3'b000) begin
            n_err++; $display("FAIL run_ignore ctrl cyc%0d: ready/core_reset/done got %b want 000", k, {oIn_Ready, oCore_Reset, oDone});
         end
      end
      iIn_Valid = 0;
      n_cmp++;
      if (q_ia.size() + q_ca.size() + q_pa.size() != 0) begin
         n_err++; $display("FAIL run_ignore writes: got %0d want 0", q_ia.size() + q_ca.size() + q_pa.size());
      end
   endtask

   task automatic test_finish_restart();
      iTask_Finished = 1;
      iStart = 1;
      @(posedge iClk); #1;
      iTask_Finished = 0;
      iStart = 0;
      @(negedge iClk);
      n_cmp++;
      if ({oDone, oCore_Reset, oIn_Ready} !== 3'b100) begin
         n_err++; $display("FAIL finish: done/core_reset/ready got %b want 100", {oDone, oCore_Reset, oIn_Ready});
      end
      @(negedge iClk);
      n_cmp++;
      if ({oDone, oCore_Reset, oIn_Ready} !== 3'b100) begin
         n_err++; $display("FAIL done_hold: done/core_reset/ready got %b want 100", {oDone, oCore_Reset, oIn_Ready});
      end
      @(posedge iClk); #1;
      pulse_start();
      @(negedge iClk);
      n_cmp++;
      if ({oDone, oCore_Reset, oIn_Ready} !== 3'b011) begin
         n_err++; $display("FAIL restart: done/core_reset/ready got %b want 011", {oDone, oCore_Reset, oIn_Ready});
      end
   endtask

   task automatic test_reset_mid_load();
      int n = 0;
      clear_q();
      iIn_Valid = 1;
      while (n < 3) begin
         iIn_Data = $urandom;
         @(posedge iClk); #1;
         n++;
      end
      iIn_Valid = 0;
      iReset = 1;
      #2;
      n_cmp++;
      if ({oIn_Ready, oDone, oCore_Reset, oBus_IMEM_Valid, oBus_CP_DMEM_Valid, oBus_PE_DMEM_Valid} !== 6'b001000 ||
          oBus_IMEM_Address !== '0 || oBus_IMEM_Write_Data !== '0) begin
         n_err++; $display("FAIL midload_reset: ready/done/core/iv/cv/pv got %b addr %0d data %h want 001000 0 0",
                           {oIn_Ready, oDone, oCore_Reset, oBus_IMEM_Valid, oBus_CP_DMEM_Valid, oBus_PE_DMEM_Valid},
                           oBus_IMEM_Address, oBus_IMEM_Write_Data);
      end
      n_cmp++;
      if (q_ia.size() != 1) begin n_err++; $display("FAIL midload_writes: got %0d imem writes want 1", q_ia.size()); end
      @(posedge iClk); #1;
      iReset = 0;
      @(negedge iClk);
      n_cmp++;
      if ({oIn_Ready, oCore_Reset} !== 2'b01) begin
         n_err++; $display("FAIL midload_idle: ready/core_reset got %b want 01", {oIn_Ready, oCore_Reset});
      end
      @(posedge iClk); #1;
      pulse_start();
      test_load("reload", 0, 0, -1);
   endtask

`ifdef SIMD_LOADER_PC_STALL_EN
   task automatic test_pc_stall();
      int k_done = -1;
      restart();
      test_load("stall_load", 0, 0, -1);
      pc_mode = 2;
      for (int k = 0; k < 42; k++) begin
         @(negedge iClk);
         n_cmp++;
         if (oDone !== 1'b0) begin n_err++; $display("FAIL stall_changing cyc%0d: done got %b want 0", k, oDone); end
      end
      pc_mode = 1;
      for (int k = 0; k < 14 && k_done < 0; k++) begin
         @(negedge iClk);
         if (oDone === 1'b1) k_done = k;
      end
      n_cmp++;
      if (k_done < 6) begin n_err++; $display("FAIL stall_hold: done at cycle %0d want 6..13", k_done); end
      pc_mode = 0;
   endtask
`endif

   initial begin
      test_reset();
      pulse_start();
      test_load("full_load", 0, 1, -1);
      test_ignored_run();
      test_finish_restart();
      test_load("gaps", 1, 0, -1);
      restart();
      test_load("start_in_cpdm", 0, 0, 2*ID + 1);
      restart();
      test_reset_mid_load();
`ifdef SIMD_LOADER_PC_STALL_EN
      test_pc_stall();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
